// File: rtl/udp_rgb16_pkg.sv
`default_nettype none
// Shared definitions for the RGB16 UDP transmit packer and receive parser.
package udp_rgb16_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HI   = 2'd1,
    S_LO   = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  localparam int UDP_MAX_PAYLOAD = 1472;

  function automatic logic [15:0] pack_rgb565(input logic [7:0] r,
                                              input logic [7:0] g,
                                              input logic [7:0] b);
    return {r[7:3], g[7:2], b[7:3]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/udp_packer_rgb16.sv
`default_nettype none
// udp_packer_rgb16: packs BGR pixels into RGB565 byte pairs on a UDP TX stream,
// splitting into fixed-size packets with frame-end early close and inter-packet gap.
module udp_packer_rgb16
  import udp_rgb16_pkg::*;
#(
  parameter int PIXELS_PER_PKT = 720,
  parameter int IPG_CYCLES     = 12
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pix_valid,
  output logic        o_pix_ready,
  input  logic [7:0]  i_channel_B,
  input  logic [7:0]  i_channel_G,
  input  logic [7:0]  i_channel_R,
  input  logic        i_pix_frame_end,
  output logic        o_udp_tx_valid,
  input  logic        i_udp_tx_ready,
  output logic [7:0]  o_udp_tx_data,
  output logic        o_udp_tx_last,
  output logic [15:0] o_pkt_count
);

  localparam int CNT_W    = $clog2(PIXELS_PER_PKT + 1);
  localparam int GAP_W    = (IPG_CYCLES > 0) ? $clog2(IPG_CYCLES + 1) : 1;
  localparam int GAP_LOAD = (IPG_CYCLES > 0) ? IPG_CYCLES - 1 : 0;
  localparam bit HAS_GAP  = (IPG_CYCLES > 0);

  state_t             state, state_nx;
  logic [15:0]        word;
  logic               last_flag;
  logic [CNT_W-1:0]   pix_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [15:0]        pkt_count;
  logic               pix_hs;
  logic               pix_last;
  logic               last_accept;

  assign pix_hs      = i_pix_valid & o_pix_ready;
  assign pix_last    = (pix_cnt == CNT_W'(PIXELS_PER_PKT - 1)) | i_pix_frame_end;
  assign last_accept = (state == S_LO) & i_udp_tx_ready & last_flag;
  assign o_pkt_count = pkt_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      word      <= '0;
      last_flag <= 1'b0;
      pix_cnt   <= '0;
      gap_cnt   <= '0;
      pkt_count <= '0;
    end else begin
      state <= state_nx;
      if (pix_hs) begin
        word      <= pack_rgb565(i_channel_R, i_channel_G, i_channel_B);
        last_flag <= pix_last;
        pix_cnt   <= pix_last ? '0 : pix_cnt + CNT_W'(1);
      end
      if (last_accept) begin
        pkt_count <= pkt_count + 16'd1;
        gap_cnt   <= GAP_W'(GAP_LOAD);
      end else if (state == S_GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
    end
  end

  // Ready is gated by reset so no pixel is taken while the block is held.
  always_comb begin
    state_nx       = state;
    o_pix_ready    = 1'b0;
    o_udp_tx_valid = 1'b0;
    o_udp_tx_data  = 8'h00;
    o_udp_tx_last  = 1'b0;
    case (state)
      S_IDLE: begin
        o_pix_ready = i_rst_n;
        if (pix_hs) state_nx = S_HI;
      end
      S_HI: begin
        o_udp_tx_valid = 1'b1;
        o_udp_tx_data  = word[15:8];
        if (i_udp_tx_ready) state_nx = S_LO;
      end
      S_LO: begin
        o_udp_tx_valid = 1'b1;
        o_udp_tx_data  = word[7:0];
        o_udp_tx_last  = last_flag;
        o_pix_ready    = i_rst_n & i_udp_tx_ready & (~last_flag | ~HAS_GAP);
        if (i_udp_tx_ready) begin
          if (last_flag && HAS_GAP) state_nx = S_GAP;
          else if (pix_hs)          state_nx = S_HI;
          else                      state_nx = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_udp_packer_rgb16.sv
`default_nettype none
// Testbench for udp_packer_rgb16: three configurations checked against a byte-queue model.
module tb_udp_packer_rgb16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       pix_valid [3];
  logic       pix_ready [3];
  logic       fe        [3];
  logic       txv       [3];
  logic       txr       [3];
  logic       txl       [3];
  logic [7:0] cr [3];
  logic [7:0] cg [3];
  logic [7:0] cb [3];
  logic [7:0] txd [3];
  logic [15:0] pc [3];

  int ppk [3] = '{4, 720, 1};

  udp_packer_rgb16 #(.PIXELS_PER_PKT(4), .IPG_CYCLES(3)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_valid(pix_valid[0]), .o_pix_ready(pix_ready[0]),
    .i_channel_B(cb[0]), .i_channel_G(cg[0]), .i_channel_R(cr[0]), .i_pix_frame_end(fe[0]),
    .o_udp_tx_valid(txv[0]), .i_udp_tx_ready(txr[0]), .o_udp_tx_data(txd[0]),
    .o_udp_tx_last(txl[0]), .o_pkt_count(pc[0]));

  udp_packer_rgb16 #(.PIXELS_PER_PKT(720), .IPG_CYCLES(12)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_valid(pix_valid[1]), .o_pix_ready(pix_ready[1]),
    .i_channel_B(cb[1]), .i_channel_G(cg[1]), .i_channel_R(cr[1]), .i_pix_frame_end(fe[1]),
    .o_udp_tx_valid(txv[1]), .i_udp_tx_ready(txr[1]), .o_udp_tx_data(txd[1]),
    .o_udp_tx_last(txl[1]), .o_pkt_count(pc[1]));

  udp_packer_rgb16 #(.PIXELS_PER_PKT(1), .IPG_CYCLES(0)) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_valid(pix_valid[2]), .o_pix_ready(pix_ready[2]),
    .i_channel_B(cb[2]), .i_channel_G(cg[2]), .i_channel_R(cr[2]), .i_pix_frame_end(fe[2]),
    .o_udp_tx_valid(txv[2]), .i_udp_tx_ready(txr[2]), .o_udp_tx_data(txd[2]),
    .o_udp_tx_last(txl[2]), .o_pkt_count(pc[2]));

  int vec = 0;
  int errs = 0;

  logic [7:0] pr [$];
  logic [7:0] pg [$];
  logic [7:0] pb [$];
  bit         pfe [$];
  logic [8:0] exp_q [$];
  logic [8:0] got_q [$];
  int gaps_q [$];
  int lat_q  [$];
  int stab_viol, bubbles, idle_between;
  bit timed_out;
  int m_cnt  [3];
  int m_pkts [3];

  function automatic void clear_all();
    pr.delete(); pg.delete(); pb.delete(); pfe.delete();
    exp_q.delete(); got_q.delete(); gaps_q.delete(); lat_q.delete();
  endfunction

  // Reference: RGB565 by integer division, packets closed by count or frame end.
  task automatic add_px(input int k, input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b, input bit f);
    int w;
    bit l;
    pr.push_back(r); pg.push_back(g); pb.push_back(b); pfe.push_back(f);
    w = (int'(r) / 8) * 2048 + (int'(g) / 4) * 32 + (int'(b) / 8);
    l = (m_cnt[k] == ppk[k] - 1) || f;
    m_cnt[k] = l ? 0 : m_cnt[k] + 1;
    if (l) m_pkts[k]++;
    exp_q.push_back({1'b0, w[15:8]});
    exp_q.push_back({l, w[7:0]});
  endtask

  task automatic stream(input int k, input int bp_pct, input bit gap_on,
                        input int stop_bytes, input int budget);
    int idx = 0;
    int cyc = 0;
    bit holding = 0;
    logic [8:0] held = '0;
    int gap_run = -1;
    int lat_run = -1;
    bit in_pkt = 0;
    stab_viol = 0; bubbles = 0; idle_between = 0; timed_out = 0;
    while ((idx < pr.size() || got_q.size() < exp_q.size() || gap_run >= 0) &&
           !(stop_bytes > 0 && got_q.size() >= stop_bytes)) begin
      if (cyc >= budget) begin
        timed_out = 1;
        break;
      end
      @(negedge clk);
      txr[k] = ($urandom_range(99) >= bp_pct);
      if (idx < pr.size()) begin
        pix_valid[k] = 1'b1;
        cr[k] = pr[idx]; cg[k] = pg[idx]; cb[k] = pb[idx]; fe[k] = pfe[idx];
      end else begin
        pix_valid[k] = 1'b0;
        fe[k] = 1'b0;
      end
      #1;
      if (txv[k] && holding && {txl[k], txd[k]} !== held) stab_viol++;
      if (in_pkt && !txv[k]) bubbles++;
      if (got_q.size() > 0 && got_q.size() < exp_q.size() && !txv[k]) idle_between++;
      if (lat_run >= 0) begin
        if (txv[k]) begin lat_q.push_back(lat_run); lat_run = -1; end
        else lat_run++;
      end
      if (gap_run >= 0) begin
        if (pix_ready[k]) begin gaps_q.push_back(gap_run); gap_run = -1; lat_run = 1; end
        else gap_run++;
      end
      if (txv[k] && txr[k]) begin
        got_q.push_back({txl[k], txd[k]});
        holding = 0;
        in_pkt = !txl[k];
        if (txl[k] && gap_on) gap_run = 0;
      end else begin
        holding = txv[k];
        held = {txl[k], txd[k]};
      end
      if (pix_valid[k] && pix_ready[k]) idx++;
      cyc++;
    end
    @(posedge clk);
    #1;
    pix_valid[k] = 1'b0;
    fe[k] = 1'b0;
    txr[k] = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pix_valid[k] = 0; fe[k] = 0; txr[k] = 1; cr[k] = 0; cg[k] = 0; cb[k] = 0;
      m_cnt[k] = 0; m_pkts[k] = 0;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      vec++;
      if ({pix_ready[k], txv[k], txl[k], txd[k], pc[k]} !== 27'd0) begin
        errs++;
        $display("FAIL reset_hold k=%0d: got rdy=%b v=%b l=%b d=%h pc=%h expected all 0",
                 k, pix_ready[k], txv[k], txl[k], txd[k], pc[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      vec++;
      if (pix_ready[k] !== 1'b1) begin
        errs++;
        $display("FAIL reset_ready k=%0d: got %b expected 1", k, pix_ready[k]);
      end
      vec++;
      if ({txv[k], txl[k], txd[k], pc[k]} !== 26'd0) begin
        errs++;
        $display("FAIL reset_outputs k=%0d: got v=%b l=%b d=%h pc=%h expected 0",
                 k, txv[k], txl[k], txd[k], pc[k]);
      end
    end
  endtask

  task automatic check_bytes(input string name);
    vec++;
    if (timed_out !== 1'b0) begin
      errs++;
      $display("FAIL %s_timeout: got %0d bytes expected %0d", name, got_q.size(), exp_q.size());
    end
    vec++;
    if (got_q.size() !== exp_q.size()) begin
      errs++;
      $display("FAIL %s_len: got %0d expected %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      vec++;
      if (got_q[i] !== exp_q[i]) begin
        errs++;
        $display("FAIL %s_byte[%0d]: got last=%b data=%h expected last=%b data=%h",
                 name, i, got_q[i][8], got_q[i][7:0], exp_q[i][8], exp_q[i][7:0]);
      end
    end
  endtask

  task automatic check_pkts(input string name, input int k);
    vec++;
    if (pc[k] !== 16'(m_pkts[k])) begin
      errs++;
      $display("FAIL %s_pkt_count: got %0d expected %0d", name, pc[k], m_pkts[k]);
    end
  endtask

  task automatic test_pattern();
    clear_all();
    add_px(0, 8'hFF, 8'h00, 8'hFF, 0);
    for (int i = 0; i < 3; i++) add_px(0, 8'h12, 8'h34, 8'h56, 0);
    stream(0, 0, 1, 0, 200);
    check_bytes("pattern");
    vec++;
    if (got_q.size() < 8 || got_q[0] !== 9'h0F8 || got_q[1] !== 9'h01F || got_q[7][8] !== 1'b1) begin
      errs++;
      $display("FAIL pattern_const: got first=%h second=%h expected 0f8 01f with last on byte 8",
               got_q.size() > 0 ? got_q[0] : 9'h1FF, got_q.size() > 1 ? got_q[1] : 9'h1FF);
    end
    vec++;
    if (gaps_q.size() != 1 || gaps_q[0] != 3) begin
      errs++;
      $display("FAIL pattern_gap: got %0d gaps first=%0d expected one gap of 3",
               gaps_q.size(), gaps_q.size() > 0 ? gaps_q[0] : -1);
    end
    check_pkts("pattern", 0);
  endtask

  task automatic test_full_packet();
    int lasts = 0;
    clear_all();
    for (int i = 0; i < 722; i++)
      add_px(1, 8'($urandom_range(255)), 8'($urandom_range(255)), 8'($urandom_range(255)), 0);
    stream(1, 0, 1, 0, 3000);
    check_bytes("full");
    foreach (got_q[i]) if (got_q[i][8]) lasts++;
    vec++;
    if (lasts != 1 || got_q.size() < 1440 || got_q[1439][8] !== 1'b1) begin
      errs++;
      $display("FAIL full_last: got %0d lasts expected one on byte 1440", lasts);
    end
    vec++;
    if (bubbles != 0) begin
      errs++;
      $display("FAIL full_bubbles: got %0d expected 0", bubbles);
    end
    vec++;
    if (gaps_q.size() != 1 || gaps_q[0] != 12) begin
      errs++;
      $display("FAIL full_gap: got %0d gaps first=%0d expected 12",
               gaps_q.size(), gaps_q.size() > 0 ? gaps_q[0] : -1);
    end
    vec++;
    if (lat_q.size() < 1 || lat_q[0] > 2) begin
      errs++;
      $display("FAIL full_restart: got %0d samples first=%0d expected <=2",
               lat_q.size(), lat_q.size() > 0 ? lat_q[0] : -1);
    end
    check_pkts("full", 1);
  endtask

  task automatic test_backpressure();
    clear_all();
    for (int i = 0; i < 20; i++)
      add_px(0, 8'($urandom_range(255)), 8'($urandom_range(255)), 8'($urandom_range(255)),
             (i == 19) || ($urandom_range(9) == 0));
    stream(0, 50, 1, 0, 2000);
    check_bytes("bp");
    vec++;
    if (stab_viol != 0) begin
      errs++;
      $display("FAIL bp_stable: got %0d changes expected 0", stab_viol);
    end
    foreach (gaps_q[i]) begin
      vec++;
      if (gaps_q[i] != 3) begin
        errs++;
        $display("FAIL bp_gap[%0d]: got %0d expected 3", i, gaps_q[i]);
      end
    end
    check_pkts("bp", 0);
  endtask

  task automatic test_frame_end();
    int lasts = 0;
    clear_all();
    for (int i = 0; i < 7; i++)
      add_px(0, 8'($urandom_range(255)), 8'($urandom_range(255)), 8'($urandom_range(255)), i == 2);
    stream(0, 0, 1, 0, 300);
    check_bytes("fe");
    foreach (got_q[i]) if (got_q[i][8]) lasts++;
    vec++;
    if (got_q.size() != 14 || lasts != 2 || got_q[5][8] !== 1'b1 || got_q[13][8] !== 1'b1) begin
      errs++;
      $display("FAIL fe_lasts: got len=%0d lasts=%0d expected len 14 with last on bytes 6 and 14",
               got_q.size(), lasts);
    end
    check_pkts("fe", 0);
  endtask

  task automatic test_no_gap();
    clear_all();
    for (int i = 0; i < 10; i++)
      add_px(2, 8'($urandom_range(255)), 8'($urandom_range(255)), 8'($urandom_range(255)), 0);
    stream(2, 0, 0, 0, 200);
    check_bytes("nogap");
    for (int i = 0; i < got_q.size(); i++) begin
      vec++;
      if (got_q[i][8] !== 1'(i % 2)) begin
        errs++;
        $display("FAIL nogap_last[%0d]: got %b expected %0d", i, got_q[i][8], i % 2);
      end
    end
    vec++;
    if (idle_between != 0) begin
      errs++;
      $display("FAIL nogap_idle: got %0d idle cycles expected 0", idle_between);
    end
    check_pkts("nogap", 2);
  endtask

  task automatic test_reset_midpkt();
    int lasts = 0;
    clear_all();
    for (int i = 0; i < 4; i++)
      add_px(0, 8'($urandom_range(255)), 8'($urandom_range(255)), 8'($urandom_range(255)), 0);
    stream(0, 0, 1, 3, 200);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vec++;
    if ({pix_ready[0], txv[0], txl[0], txd[0], pc[0]} !== 27'd0) begin
      errs++;
      $display("FAIL midrst_outputs: got rdy=%b v=%b l=%b d=%h pc=%h expected all 0",
               pix_ready[0], txv[0], txl[0], txd[0], pc[0]);
    end
    for (int k = 0; k < 3; k++) begin m_cnt[k] = 0; m_pkts[k] = 0; end
    @(negedge clk);
    rst_n = 1'b1;
    clear_all();
    for (int i = 0; i < 4; i++)
      add_px(0, 8'($urandom_range(255)), 8'($urandom_range(255)), 8'($urandom_range(255)), 0);
    stream(0, 0, 1, 0, 200);
    check_bytes("midrst");
    foreach (got_q[i]) if (got_q[i][8]) lasts++;
    vec++;
    if (got_q.size() != 8 || lasts != 1 || got_q[7][8] !== 1'b1) begin
      errs++;
      $display("FAIL midrst_len: got len=%0d lasts=%0d expected 8 bytes with one last",
               got_q.size(), lasts);
    end
    check_pkts("midrst", 0);
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_full_packet();
    test_backpressure();
    test_frame_end();
    test_no_gap();
    test_reset_midpkt();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
`default_nettype wire
